// File: rtl/hazard_ctrl.sv
// +----------------------------------------------------------------------------+
// | hazard_ctrl : ID-stage hazard, divider-hold and flush controller with      |
// |               saturating stall/flush performance counters.                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module hazard_ctrl #(
  parameter int DIV_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_is_div,
  input  logic             id_pcsrc,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_writereg,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       mem_writereg,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             exmem_bubble,
  output logic             ifid_flush,
  output logic             div_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic       RUN      = 1'b0;
  localparam logic       DIV_BUSY = 1'b1;
  localparam logic [3:0] DIV_INIT = 4'(DIV_CYCLES - 1);

  logic             state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic h_lu, h_br, haz;
  logic stall_w, hold_w, bubble_w, flush_w;

  always_comb begin
    ex_rs_hit  = ex_regwrite  && (ex_writereg  != 5'd0) && (ex_writereg  == id_rs);
    ex_rt_hit  = ex_regwrite  && (ex_writereg  != 5'd0) && (ex_writereg  == id_rt);
    mem_rs_hit = mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == id_rs);
    mem_rt_hit = mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == id_rt);

    h_lu = ex_memread && (ex_rs_hit || (id_uses_rt && ex_rt_hit));
    // Branches resolve in ID, so even an ALU result still in EX is too late.
    h_br = id_is_branch && (ex_rs_hit || ex_rt_hit ||
                            (mem_memread && (mem_rs_hit || mem_rt_hit)));
    haz  = id_valid && (h_lu || h_br);

    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_w  = 1'b0;
    hold_w   = 1'b0;
    bubble_w = 1'b0;
    flush_w  = 1'b0;

    if (state_q == DIV_BUSY) begin
      stall_w = 1'b1;
      hold_w  = 1'b1;
      cnt_d   = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = RUN;
      end
    end else begin
      stall_w  = haz;
      bubble_w = haz;
      flush_w  = id_pcsrc && !haz;
      if (id_valid && id_is_div && !haz) begin
        state_d = DIV_BUSY;
        cnt_d   = DIV_INIT;
      end
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_w && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_w && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Gate with rst so every output drops the instant reset is asserted.
  assign pc_stall     = !rst && stall_w;
  assign ifid_stall   = !rst && stall_w;
  assign idex_bubble  = !rst && bubble_w;
  assign idex_hold    = !rst && hold_w;
  assign exmem_bubble = !rst && hold_w;
  assign ifid_flush   = !rst && flush_w;
  assign div_busy     = !rst && (state_q == DIV_BUSY);
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

`default_nettype wire
